wb_stage_p: RTL and testbench

Parameterised MEM/WB pipeline register and write-back stage for the pipelined RISC-V core. It captures one instruction per cycle from the MEM stage and selects the write-back value: ALU result, load data, PC+4, or U-immediate. Load data is aligned and sign- or zero-extended here. Variable-latency data-memory read responses are handled with a valid/ready handshake toward MEM, and the stage drives the register-file write port.

---
 rtl/wb_stage_p.sv | 166 ++++++++++++++++
 tb/tb_wb_stage_p.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_p.sv
// wb_stage_p: MEM/WB pipeline register and write-back stage.
// Captures one instruction per cycle from MEM, selects the write-back value
// (ALU, aligned/extended load data, PC+4 or U-immediate), waits for
// variable-latency load data and drives the register-file write port.
// Optional feature macro: WB_FWD_EN adds the EX-stage bypass outputs
// (fwd_valid, fwd_rd, fwd_data) and the load-use hazard flag fwd_busy.
module wb_stage_p #(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_flush,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic [1:0]      mem_memtoreg,
  input  logic [2:0]      mem_funct3,
  input  logic [OFFW-1:0] mem_addr_lo,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic [XLEN-1:0] mem_imm,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire,
  output logic [31:0]     wait_cycles
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            fwd_busy
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [4:0]      rd_q;
  logic            wr_q;      // write intent, already qualified with rd != 0
  logic [2:0]      f3_q;
  logic [OFFW-1:0] lo_q;
  logic [XLEN-1:0] data_q;
  logic [31:0]     wait_q;

  logic            capture;
  logic            is_load;
  logic [XLEN-1:0] res_sel;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_data;
  logic            ld_legal;

  // A load parks the stage until its data returns; FULL drains and refills.
  assign mem_ready = (state_q != ST_WAIT);
  assign capture   = mem_valid && mem_ready;
  assign is_load   = (mem_memtoreg == SEL_LOAD);

  // Non-load result select (load encoding never reaches data_q from here)
  always_comb begin
    res_sel = mem_alu;
    case (mem_memtoreg)
      SEL_ALU: res_sel = mem_alu;
      SEL_PC4: res_sel = mem_pc4;
      2'b11:   res_sel = mem_imm;
      default: res_sel = mem_alu;
    endcase
  end

  // Bring the addressed byte lane down to bit 0 before extending.
  assign shifted = dmem_rdata >> {lo_q, 3'b000};

  // Load width/extension; sized casts of signed slices sign-extend.
  always_comb begin
    ld_data  = '0;
    ld_legal = 1'b1;
    case (f3_q)
      3'b000: ld_data = XLEN'($signed(shifted[7:0]));
      3'b100: ld_data = XLEN'(shifted[7:0]);
      3'b001: ld_data = XLEN'($signed(shifted[15:0]));
      3'b101: ld_data = XLEN'(shifted[15:0]);
      3'b010: ld_data = XLEN'($signed(shifted[31:0]));
      3'b110: begin
        if (XLEN == 64) ld_data = XLEN'(shifted[31:0]);
        else            ld_legal = 1'b0;
      end
      3'b011: begin
        if (XLEN == 64) ld_data = shifted;
        else            ld_legal = 1'b0;
      end
      default: ld_legal = 1'b0;
    endcase
  end

  // Next-state: capture decides in EMPTY/FULL, rvalid releases WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (dmem_rvalid) state_d = ST_FULL;
      end
      default: begin
        if (capture) begin
          if (mem_flush)    state_d = ST_EMPTY;
          else if (is_load) state_d = ST_WAIT;
          else              state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  // State register and captured entry; flushed captures leave fields untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      lo_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture && !mem_flush) begin
        rd_q <= mem_rd;
        wr_q <= mem_reg_write && (mem_rd != 5'd0);
        f3_q <= mem_funct3;
        lo_q <= mem_addr_lo;
        if (!is_load) data_q <= res_sel;
      end else if ((state_q == ST_WAIT) && dmem_rvalid) begin
        data_q <= ld_data;
        wr_q   <= wr_q && ld_legal;
      end
    end
  end

  // Saturating count of cycles spent waiting on load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         wait_q <= '0;
    else if ((state_q == ST_WAIT) && (wait_q != '1)) wait_q <= wait_q + 32'd1;
  end

  assign retire      = (state_q == ST_FULL);
  assign rf_we       = (state_q == ST_FULL) && wr_q;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = data_q;
  assign wait_cycles = wait_q;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
  assign fwd_busy  = (state_q == ST_WAIT) && (rd_q != 5'd0);
`endif

endmodule

// File: tb/tb_wb_stage_p.sv
// Directed bench for wb_stage_p: a 32-bit and a 64-bit instance share the
// control inputs; each has its own mem_valid so only one captures at a time.
module tb_wb_stage_p;

  logic        clk, rst;
  logic        v32, v64;
  logic        mem_flush, mem_reg_write, dmem_rvalid;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_memtoreg;
  logic [2:0]  mem_funct3, addr_lo;
  logic [63:0] alu, pc4, imm, rdata;

  logic        rdy32, we32, ret32, rdy64, we64, ret64;
  logic [4:0]  wa32, wa64;
  logic [31:0] wd32, wc32, wc64;
  logic [63:0] wd64;
`ifdef WB_FWD_EN
  logic        fv32, fb32, fv64, fb64;
  logic [4:0]  fr32, fr64;
  logic [31:0] fd32;
  logic [63:0] fd64;
`endif

  int checks = 0;
  int errors = 0;
  int exp_wc32 = 0;
  int exp_wc64 = 0;

  wb_stage_p #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .mem_valid(v32), .mem_ready(rdy32), .mem_flush(mem_flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_funct3(mem_funct3), .mem_addr_lo(addr_lo[1:0]), .mem_alu(alu[31:0]),
    .mem_pc4(pc4[31:0]), .mem_imm(imm[31:0]), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(rdata[31:0]), .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32),
    .retire(ret32), .wait_cycles(wc32)
`ifdef WB_FWD_EN
    , .fwd_valid(fv32), .fwd_rd(fr32), .fwd_data(fd32), .fwd_busy(fb32)
`endif
  );

  wb_stage_p #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .mem_valid(v64), .mem_ready(rdy64), .mem_flush(mem_flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_funct3(mem_funct3), .mem_addr_lo(addr_lo), .mem_alu(alu),
    .mem_pc4(pc4), .mem_imm(imm), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(rdata), .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64),
    .retire(ret64), .wait_cycles(wc64)
`ifdef WB_FWD_EN
    , .fwd_valid(fv64), .fwd_rd(fr64), .fwd_data(fd64), .fwd_busy(fb64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture a load on one instance, hold it for nwait WAIT cycles (rvalid in
  // the last one), then check the write-back cycle and drain to EMPTY.
  task automatic do_load(input bit w64, input logic [2:0] f3, input logic [2:0] lo,
                         input logic [4:0] rd, input logic [63:0] rd_word, input int nwait,
                         input bit exp_we, input logic [63:0] exp_data, input string tag);
    v32 = !w64; v64 = w64; mem_flush = 1'b0; mem_reg_write = 1'b1;
    mem_memtoreg = 2'b01; mem_funct3 = f3; addr_lo = lo; mem_rd = rd; rdata = rd_word;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    for (int k = 0; k < nwait; k++) begin
      if (k == nwait - 1) dmem_rvalid = 1'b1;
      @(negedge clk);
      chk({tag, "_ready"}, w64 ? rdy64 : rdy32, 64'd0);
`ifdef WB_FWD_EN
      chk({tag, "_busy"}, w64 ? fb64 : fb32, {63'd0, rd != 5'd0});
`endif
      if (w64) exp_wc64++; else exp_wc32++;
      @(posedge clk); #1;
    end
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_we"},     w64 ? we64 : we32, {63'd0, exp_we});
    chk({tag, "_retire"}, w64 ? ret64 : ret32, 64'd1);
    chk({tag, "_waddr"},  w64 ? wa64 : wa32, {59'd0, rd});
    chk({tag, "_wdata"},  w64 ? wd64 : {32'd0, wd32}, exp_data);
    chk({tag, "_wcyc"},   w64 ? wc64 : wc32, w64 ? 64'(exp_wc64) : 64'(exp_wc32));
    chk({tag, "_ready_full"}, w64 ? rdy64 : rdy32, 64'd1);
`ifdef WB_FWD_EN
    chk({tag, "_fwd_valid"}, w64 ? fv64 : fv32, {63'd0, exp_we});
    chk({tag, "_fwd_data"},  w64 ? fd64 : {32'd0, fd32}, exp_data);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; v32 = 1'b0; v64 = 1'b0; mem_flush = 1'b0; mem_reg_write = 1'b0;
    dmem_rvalid = 1'b0; mem_rd = '0; mem_memtoreg = '0; mem_funct3 = '0; addr_lo = '0;
    alu = '0; pc4 = '0; imm = '0; rdata = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we",     we32, 64'd0);
    chk("rst_waddr",  wa32, 64'd0);
    chk("rst_wdata",  wd32, 64'd0);
    chk("rst_retire", ret32, 64'd0);
    chk("rst_wcyc",   wc32, 64'd0);
    chk("rst_wdata64", wd64, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("rst_ready32", rdy32, 64'd1);
    chk("rst_ready64", rdy64, 64'd1);

    // Reset while a load is waiting; a late rvalid must be ignored
    @(posedge clk); #1;
    v32 = 1'b1; mem_memtoreg = 2'b01; mem_funct3 = 3'b010; mem_rd = 5'd7; mem_reg_write = 1'b1;
    @(posedge clk); #1 v32 = 1'b0;
    @(negedge clk);
    chk("rstw_ready_wait", rdy32, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; dmem_rvalid = 1'b1; rdata = 64'h1234_5678;
    @(posedge clk); #1 dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstw_we",     we32, 64'd0);
    chk("rstw_retire", ret32, 64'd0);
    chk("rstw_wcyc",   wc32, 64'd0);
    chk("rstw_ready",  rdy32, 64'd1);
    exp_wc32 = 0; exp_wc64 = 0;

    // Three back-to-back ALU ops
    @(posedge clk); #1;
    mem_memtoreg = 2'b00; mem_reg_write = 1'b1; v32 = 1'b1; mem_rd = 5'd1; alu = 64'h11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin mem_rd = 5'(i + 2); alu = 64'(8'h11 * (i + 2)); end
      else v32 = 1'b0;
      @(negedge clk);
      chk($sformatf("alu%0d_we", i),    we32, 64'd1);
      chk($sformatf("alu%0d_waddr", i), wa32, 64'(i + 1));
      chk($sformatf("alu%0d_wdata", i), wd32, 64'(8'h11 * (i + 1)));
      chk($sformatf("alu%0d_ready", i), rdy32, 64'd1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("alu_drain_retire", ret32, 64'd0);

    // Loads on the 32-bit instance
    do_load(1'b0, 3'b000, 3'd3, 5'd4, 64'h80FF_0000, 2, 1'b1, 64'hFFFF_FF80, "lb");
    do_load(1'b0, 3'b101, 3'd2, 5'd6, 64'h8001_1234, 1, 1'b1, 64'h0000_8001, "lhu");
    do_load(1'b0, 3'b001, 3'd2, 5'd6, 64'h8001_1234, 1, 1'b1, 64'hFFFF_8001, "lh");
    do_load(1'b0, 3'b100, 3'd1, 5'd8, 64'h0000_9A00, 1, 1'b1, 64'h0000_009A, "lbu");
    do_load(1'b0, 3'b011, 3'd0, 5'd9, 64'hCAFE_F00D, 1, 1'b0, 64'h0, "ill_ld32");
    do_load(1'b0, 3'b111, 3'd0, 5'd9, 64'hCAFE_F00D, 1, 1'b0, 64'h0, "ill_111");

    // JAL to x0 retires without writing, then a flushed JAL to x5
    v32 = 1'b1; mem_memtoreg = 2'b10; mem_reg_write = 1'b1; mem_rd = 5'd0; pc4 = 64'h104;
    @(posedge clk); #1;
    mem_rd = 5'd5; mem_flush = 1'b1;
    @(negedge clk);
    chk("jal0_retire", ret32, 64'd1);
    chk("jal0_we",     we32, 64'd0);
    chk("jal0_wdata",  wd32, 64'h104);
    @(posedge clk); #1 v32 = 1'b0; mem_flush = 1'b0;
    @(negedge clk);
    chk("jalf_retire", ret32, 64'd0);
    chk("jalf_we",     we32, 64'd0);
    chk("jalf_ready",  rdy32, 64'd1);

    // U-immediate select
    @(posedge clk); #1;
    v32 = 1'b1; mem_memtoreg = 2'b11; mem_rd = 5'd9; imm = 64'hABCD_0000;
    @(posedge clk); #1 v32 = 1'b0;
    @(negedge clk);
    chk("imm_we",    we32, 64'd1);
    chk("imm_wdata", wd32, 64'hABCD_0000);
    @(posedge clk); #1;

    // 64-bit instance
    do_load(1'b1, 3'b110, 3'd4, 5'd10, 64'hDEAD_BEEF_0000_0000, 1, 1'b1, 64'h0000_0000_DEAD_BEEF, "lwu64");
    do_load(1'b1, 3'b011, 3'd0, 5'd11, 64'h0123_4567_89AB_CDEF, 2, 1'b1, 64'h0123_4567_89AB_CDEF, "ld64");
    do_load(1'b1, 3'b010, 3'd0, 5'd12, 64'h0000_0000_8000_0000, 1, 1'b1, 64'hFFFF_FFFF_8000_0000, "lw64");
    do_load(1'b1, 3'b000, 3'd7, 5'd13, 64'h8000_0000_0000_0000, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, "lb64");
    chk("wcyc32_final", wc32, 64'(exp_wc32));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
